bram_debug_sequencer: RTL and testbench
=======================================

Name: bram_debug_sequencer

Overview:
- Hardware replacement for bench-driven BRAM init/readback.
- Sequences the second (debug) port of the Instruction and Data BRAMs: loads words from a stream, releases the core from reset for a fixed run window, then dumps BRAM contents to an output stream.
- Sits between a host link (UART/JTAG bridge) and the RV32Core debug ports. The core stays in reset whenever the sequencer is not in the run window.

Parameters:
- BRAM_WORDS, 4096, words per BRAM (32-bit each).
- LEN_W, 13, width of the length field; holds 0..BRAM_WORDS.
- RST_CYCLES, 5, cycles core_rst stays asserted at the start of a run.
- RUN_CYCLES, 200000, cycles the core executes before it is frozen.

Ports:
- CPU_CLK  in  1  clock
- CPU_RST  in  1  synchronous, active-low reset
- cmd_valid  in  1  command handshake valid
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 LOAD, 01 DUMP, 10 RUN, 11 reserved (accepted, no-op, done pulse)
- cmd_sel  in  1  0 = DataRAM, 1 = InstRAM
- cmd_len  in  LEN_W  word count for LOAD/DUMP
- wr_valid / wr_ready / wr_data  in / out / in  1/1/32  load stream
- rd_valid / rd_ready / rd_data  out / in / out  1/1/32  dump stream
- dbg_a2  out  32  shared debug byte address to both BRAMs
- dbg_wd2  out  32  debug write data
- data_we2  out  4  DataRAM debug byte enables
- inst_we2  out  4  InstRAM debug byte enables
- data_rd2  in  32  DataRAM debug read data
- inst_rd2  in  32  InstRAM debug read data
- core_rst  out  1  active-high reset to the core
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a command completes
- checksum  out  32  see Optional Feature

Behaviour:
- Reset values (CPU_RST = 0 at a clock edge):
  - state IDLE; dbg_a2, dbg_wd2 = 0.
  - data_we2, inst_we2 = 0.
  - core_rst = 1; rd_valid, wr_ready, done, busy = 0.
  - checksum = 0.
- Reset mid-operation aborts the command immediately; no partial write is completed afterwards.
- All outputs are registered except cmd_ready and wr_ready, which decode state.
- States: IDLE, LOAD, DUMP_ADDR, DUMP_WAIT, DUMP_OUT, RUN_RST, RUN, DONE.
- IDLE:
  - cmd_valid && cmd_ready latches op/sel/len.
  - len is clamped to BRAM_WORDS; word index is cleared to 0.
  - LOAD or DUMP with len = 0 goes straight to DONE.
- LOAD:
  - wr_ready = 1.
  - Each wr handshake: next cycle dbg_a2 = index*4, dbg_wd2 = wr_data, and the selected WE = 4'b1111 for exactly one cycle (other WE = 0).
  - index increments per handshake; after the len-th handshake go to DONE.
  - wr_valid low inserts idle cycles with WE = 0.
- DUMP_ADDR:
  - Drive dbg_a2 = index*4, WE = 0; go to DUMP_WAIT.
  - BRAM read latency is 1 cycle.
- DUMP_WAIT: capture the selected rd2 into rd_data; set rd_valid; go to DUMP_OUT.
- DUMP_OUT:
  - Hold rd_valid and rd_data stable until rd_ready.
  - On handshake, drop rd_valid and increment index: go to DONE if index = len, else to DUMP_ADDR.
  - Throughput: one word per 3 cycles maximum.
- RUN_RST: core_rst = 1 for RST_CYCLES cycles; go to RUN.
- RUN:
  - core_rst = 0 and WE = 0 for RUN_CYCLES cycles.
  - Then core_rst = 1 (core frozen, BRAM contents preserved); go to DONE.
- DONE: done = 1 for one cycle; go to IDLE.
- Address wrap: index never exceeds BRAM_WORDS-1 because of the clamp, so the maximum dbg_a2 is 0x3FFC.
- Ignored inputs: wr_valid outside LOAD, rd_ready outside DUMP_OUT, and cmd_valid while busy are all ignored.
- core_rst is 1 in every state except RUN.

Optional Feature:
- Macro: BRAM_DEBUG_SEQ_CHECKSUM_EN.
- With the macro:
  - checksum is cleared when a LOAD or DUMP command is accepted.
  - On each wr handshake (LOAD) or rd handshake (DUMP) it updates as checksum + data, modulo 2^32.
  - It holds its value after done.
- Without the macro: checksum is tied to 0 and the adder is not synthesised.

Test Plan:
- Reset check: hold CPU_RST = 0 for 3 cycles -> core_rst = 1, data_we2 = inst_we2 = 0, cmd_ready = 1, busy = 0.
- LOAD inst, len = 3, words 00000013, 00100093, 00208133 -> inst_we2 = 1111 at dbg_a2 0x0, 0x4, 0x8; data_we2 stays 0; one done pulse.
- DUMP data, len = 2, model BRAM holding 0xDEADBEEF at 0x0 and 0x12345678 at 0x4, with rd_ready stalled 4 cycles on word 0 -> rd_data stable during the stall; outputs DEADBEEF then 12345678; done pulses.
- RUN with RST_CYCLES = 5, RUN_CYCLES = 100 -> core_rst high for 5 cycles after acceptance, low for exactly 100 cycles, high again; done pulses the cycle after.
- Length edges:
  - LOAD len = 0 -> done within 2 cycles, no WE activity.
  - LOAD len = 5000 -> clamped to 4096 writes, last dbg_a2 = 0x3FFC.
- Reset mid-LOAD after 2 of 4 words -> WE = 0 and state IDLE the next cycle, no further writes. With BRAM_DEBUG_SEQ_CHECKSUM_EN, loading 1, 2, 3 gives checksum = 6.

Source files
------------

// File: rtl/bram_debug_sequencer.sv
// Debug-port sequencer for the Inst/Data BRAMs: host load, timed core run and dump.
// Define BRAM_DEBUG_SEQ_CHECKSUM_EN to enable the running 32-bit word checksum.
module bram_debug_sequencer #(
  parameter int BRAM_WORDS = 4096,
  parameter int LEN_W      = 13,
  parameter int RST_CYCLES = 5,
  parameter int RUN_CYCLES = 200000
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_sel,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_data,
  output logic [31:0]      dbg_a2,
  output logic [31:0]      dbg_wd2,
  output logic [3:0]       data_we2,
  output logic [3:0]       inst_we2,
  input  logic [31:0]      data_rd2,
  input  logic [31:0]      inst_rd2,
  output logic             core_rst,
  output logic             busy,
  output logic             done,
  output logic [31:0]      checksum
);

  typedef enum logic [2:0] {
    IDLE, LOAD, DUMP_ADDR, DUMP_WAIT, DUMP_OUT, RUN_RST, RUN, DONE
  } state_t;

  localparam logic [1:0]       OP_LOAD  = 2'b00;
  localparam logic [1:0]       OP_DUMP  = 2'b01;
  localparam logic [1:0]       OP_RUN   = 2'b10;
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(BRAM_WORDS);
  localparam logic [31:0]      RST_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0]      RUN_LAST = 32'(RUN_CYCLES - 1);

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] idx_inc;
  logic [LEN_W-1:0] len_clamped;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      dbg_a2_q, dbg_a2_d;
  logic [31:0]      dbg_wd2_q, dbg_wd2_d;
  logic [3:0]       data_we2_q, data_we2_d;
  logic [3:0]       inst_we2_q, inst_we2_d;
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             core_rst_q, core_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic [31:0] word_addr(input logic [LEN_W-1:0] i);
    return {{(30-LEN_W){1'b0}}, i, 2'b00};
  endfunction

  assign idx_inc     = idx_q + 1'b1;
  assign len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    len_d      = len_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    dbg_a2_d   = dbg_a2_q;
    dbg_wd2_d  = dbg_wd2_q;
    data_we2_d = 4'h0;
    inst_we2_d = 4'h0;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          sel_d = cmd_sel;
          len_d = len_clamped;
          idx_d = '0;
          cnt_d = '0;
          case (cmd_op)
            OP_LOAD: state_d = (len_clamped == '0) ? DONE : LOAD;
            OP_DUMP: begin
              state_d  = (len_clamped == '0) ? DONE : DUMP_ADDR;
              dbg_a2_d = '0;
            end
            OP_RUN:  state_d = RUN_RST;
            default: state_d = DONE;
          endcase
        end
      end
      LOAD: begin
        if (wr_valid) begin
          dbg_a2_d  = word_addr(idx_q);
          dbg_wd2_d = wr_data;
          if (sel_q) inst_we2_d = 4'hF;
          else       data_we2_d = 4'hF;
          idx_d = idx_inc;
          if (idx_inc == len_q) state_d = DONE;
        end
      end
      DUMP_ADDR: state_d = DUMP_WAIT;
      DUMP_WAIT: begin
        rd_data_d  = sel_q ? inst_rd2 : data_rd2;
        rd_valid_d = 1'b1;
        state_d    = DUMP_OUT;
      end
      DUMP_OUT: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          idx_d      = idx_inc;
          if (idx_inc == len_q) begin
            state_d = DONE;
          end else begin
            // Address is presented on entry to DUMP_ADDR so rd2 is ready in DUMP_WAIT.
            state_d  = DUMP_ADDR;
            dbg_a2_d = word_addr(idx_inc);
          end
        end
      end
      RUN_RST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RUN: begin
        if (cnt_q == RUN_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    core_rst_d = (state_d != RUN);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      len_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      dbg_a2_q   <= '0;
      dbg_wd2_q  <= '0;
      data_we2_q <= 4'h0;
      inst_we2_q <= 4'h0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      dbg_a2_q   <= dbg_a2_d;
      dbg_wd2_q  <= dbg_wd2_d;
      data_we2_q <= data_we2_d;
      inst_we2_q <= inst_we2_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef BRAM_DEBUG_SEQ_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  // Running sum of every word that crosses the load or dump stream.
  always_comb begin
    checksum_d = checksum_q;
    if (state_q == IDLE && cmd_valid && (cmd_op == OP_LOAD || cmd_op == OP_DUMP))
      checksum_d = '0;
    else if (state_q == LOAD && wr_valid)
      checksum_d = checksum_q + wr_data;
    else if (state_q == DUMP_OUT && rd_ready)
      checksum_d = checksum_q + rd_data_q;
  end

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST) checksum_q <= '0;
    else          checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == LOAD);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign dbg_a2    = dbg_a2_q;
  assign dbg_wd2   = dbg_wd2_q;
  assign data_we2  = data_we2_q;
  assign inst_we2  = inst_we2_q;
  assign core_rst  = core_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bram_debug_sequencer.sv
// Self-checking bench for bram_debug_sequencer: BRAM model, random streams, reference memory model.
module tb_bram_debug_sequencer;

  logic        CPU_CLK;
  logic        CPU_RST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_sel;
  logic [12:0] cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic [31:0] dbg_a2;
  logic [31:0] dbg_wd2;
  logic [3:0]  data_we2;
  logic [3:0]  inst_we2;
  logic [31:0] data_rd2;
  logic [31:0] inst_rd2;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  bram_debug_sequencer #(
    .BRAM_WORDS(4096),
    .LEN_W(13),
    .RST_CYCLES(5),
    .RUN_CYCLES(100)
  ) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .dbg_a2(dbg_a2), .dbg_wd2(dbg_wd2),
    .data_we2(data_we2), .inst_we2(inst_we2),
    .data_rd2(data_rd2), .inst_rd2(inst_rd2),
    .core_rst(core_rst), .busy(busy), .done(done), .checksum(checksum)
  );

  typedef struct {
    logic        sel;
    logic        both;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] data;
  } wrEntry_t;

  int          errors = 0;
  int          checks = 0;
  int          doneCount = 0;
  wrEntry_t    writeLog[$];
  wrEntry_t    ent;
  logic [31:0] stimWords[$];
  logic [31:0] dataRam [0:4095];
  logic [31:0] instRam [0:4095];
  logic [31:0] modelMem [0:1][0:4095];

  initial CPU_CLK = 1'b0;
  always #5 CPU_CLK = ~CPU_CLK;

  // Behavioural BRAM debug ports: synchronous write, one-cycle registered read.
  always @(posedge CPU_CLK) begin
    if (data_we2 == 4'hF) dataRam[dbg_a2[13:2]] <= dbg_wd2;
    if (inst_we2 == 4'hF) instRam[dbg_a2[13:2]] <= dbg_wd2;
    data_rd2 <= dataRam[dbg_a2[13:2]];
    inst_rd2 <= instRam[dbg_a2[13:2]];
  end

  // Log every cycle with any write enable and count done-high cycles.
  always @(negedge CPU_CLK) begin
    if (done === 1'b1) doneCount++;
    if (data_we2 !== 4'h0 || inst_we2 !== 4'h0) begin
      ent.sel  = (inst_we2 !== 4'h0);
      ent.both = (inst_we2 !== 4'h0) && (data_we2 !== 4'h0);
      ent.we   = data_we2 | inst_we2;
      ent.addr = dbg_a2;
      ent.data = dbg_wd2;
      writeLog.push_back(ent);
    end
  end

  task automatic tick();
    @(posedge CPU_CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expectSum(input logic [31:0] s);
`ifdef BRAM_DEBUG_SEQ_CHECKSUM_EN
    return s;
`else
    return 32'h0 & s;
`endif
  endfunction

  task automatic applyStimulus(input logic [1:0] op, input logic sel, input logic [12:0] len);
    int b;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sel   = sel;
    cmd_len   = len;
    b = 0;
    while (!cmd_ready && b < 1000) begin
      tick();
      b++;
    end
    tick();
    cmd_valid = 1'b0;
    cmd_op    = $urandom_range(0, 3);
    cmd_len   = 13'($urandom);
  endtask

  task automatic waitIdle();
    int b;
    b = 0;
    while ((busy !== 1'b0 || cmd_ready !== 1'b1) && b < 1000) begin
      tick();
      b++;
    end
    checkOutput("idleTimeout", 32'(b < 1000), 32'd1);
  endtask

  task automatic doLoad(input logic sel, input int len, input bit fullRate);
    int n, sent, budget, bad, d0;
    bit hs;
    logic [31:0] expSum;
    n = (len > 4096) ? 4096 : len;
    writeLog.delete();
    d0 = doneCount;
    applyStimulus(2'b00, sel, 13'(len));
    sent = 0;
    budget = 0;
    while (sent < n && budget < 50000) begin
      wr_valid = fullRate ? 1'b1 : ($urandom_range(0, 3) != 0);
      wr_data  = stimWords[sent];
      hs = wr_valid && wr_ready;
      tick();
      budget++;
      if (hs) sent++;
    end
    wr_valid = 1'b0;
    checkOutput("loadTimeout", sent, n);
    waitIdle();
    checkOutput("loadDone", doneCount - d0, 1);
    checkOutput("loadCount", writeLog.size(), n);
    bad = 0;
    for (int i = 0; i < writeLog.size(); i++) begin
      if (i >= n) bad++;
      else if (writeLog[i].we !== 4'hF || writeLog[i].both !== 1'b0 ||
               writeLog[i].sel !== sel || writeLog[i].addr !== 32'(i * 4) ||
               writeLog[i].data !== stimWords[i]) bad++;
    end
    checkOutput("loadEntries", bad, 0);
    expSum = 0;
    for (int i = 0; i < n; i++) begin
      modelMem[sel][i] = stimWords[i];
      expSum += stimWords[i];
    end
    checkOutput("loadSum", checksum, expectSum(expSum));
  endtask

  task automatic doDump(input logic sel, input int len, input int stall);
    int n, budget, d0, stallLeft;
    bit hs, pv;
    logic [31:0] pd, expSum;
    logic [31:0] got[$];
    n = (len > 4096) ? 4096 : len;
    writeLog.delete();
    d0 = doneCount;
    stallLeft = stall;
    applyStimulus(2'b01, sel, 13'(len));
    budget = 0;
    while (got.size() < n && budget < 20000) begin
      if (rd_valid) begin
        if (stallLeft > 0) begin
          rd_ready = 1'b0;
          stallLeft--;
        end else begin
          rd_ready = ($urandom_range(0, 2) != 0);
        end
      end else begin
        rd_ready = $urandom_range(0, 1);
      end
      hs = rd_valid && rd_ready;
      pv = rd_valid;
      pd = rd_data;
      tick();
      budget++;
      if (hs) got.push_back(pd);
      else if (pv) begin
        checkOutput("dumpHoldValid", 32'(rd_valid), 32'd1);
        checkOutput("dumpHoldData", rd_data, pd);
      end
    end
    rd_ready = 1'b0;
    checkOutput("dumpTimeout", got.size(), n);
    waitIdle();
    checkOutput("dumpDone", doneCount - d0, 1);
    checkOutput("dumpNoWrite", writeLog.size(), 0);
    expSum = 0;
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) checkOutput("dumpWord", got[i], modelMem[sel][i]);
      expSum += modelMem[sel][i];
    end
    checkOutput("dumpSum", checksum, expectSum(expSum));
  endtask

  initial begin
    int d0, hi, lo;
    logic rs;

    for (int i = 0; i < 4096; i++) begin
      dataRam[i] = 32'h0;
      instRam[i] = 32'h0;
      modelMem[0][i] = 32'h0;
      modelMem[1][i] = 32'h0;
    end
    CPU_RST = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_sel = 1'b0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

    repeat (3) tick();
    checkOutput("rstCoreRst", 32'(core_rst), 32'd1);
    checkOutput("rstDataWe", 32'(data_we2), 32'd0);
    checkOutput("rstInstWe", 32'(inst_we2), 32'd0);
    checkOutput("rstCmdReady", 32'(cmd_ready), 32'd1);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstRdValid", 32'(rd_valid), 32'd0);
    checkOutput("rstWrReady", 32'(wr_ready), 32'd0);
    checkOutput("rstAddr", dbg_a2, 32'd0);
    checkOutput("rstChecksum", checksum, 32'd0);
    CPU_RST = 1'b1;
    tick();

    stimWords = '{32'h00000013, 32'h00100093, 32'h00208133};
    doLoad(1'b1, 3, 1'b0);

    stimWords = '{32'hDEADBEEF, 32'h12345678};
    doLoad(1'b0, 2, 1'b0);
    doDump(1'b0, 2, 4);
    doDump(1'b1, 3, 0);

    writeLog.delete();
    d0 = doneCount;
    applyStimulus(2'b10, 1'b0, 13'd0);
    wr_valid = 1'b1;
    wr_data  = $urandom;
    hi = 0;
    while (core_rst && hi < 1000) begin hi++; tick(); end
    lo = 0;
    while (!core_rst && lo < 1000) begin lo++; tick(); end
    wr_valid = 1'b0;
    checkOutput("runRstCycles", hi, 5);
    checkOutput("runCycles", lo, 100);
    checkOutput("runDoneAfter", 32'(done), 32'd1);
    checkOutput("runCoreRstBack", 32'(core_rst), 32'd1);
    waitIdle();
    checkOutput("runDone", doneCount - d0, 1);
    checkOutput("runNoWrite", writeLog.size(), 0);

    writeLog.delete();
    d0 = doneCount;
    applyStimulus(2'b00, 1'b0, 13'd0);
    checkOutput("len0DoneQuick", 32'(done), 32'd1);
    waitIdle();
    checkOutput("len0Done", doneCount - d0, 1);
    checkOutput("len0NoWrite", writeLog.size(), 0);

    writeLog.delete();
    d0 = doneCount;
    applyStimulus(2'b11, 1'b1, 13'd5);
    checkOutput("rsvdDoneQuick", 32'(done), 32'd1);
    waitIdle();
    checkOutput("rsvdDone", doneCount - d0, 1);
    checkOutput("rsvdNoWrite", writeLog.size(), 0);

    stimWords = '{32'd1, 32'd2, 32'd3};
    doLoad(1'b0, 3, 1'b0);
    checkOutput("sum123", checksum, expectSum(32'd6));

    for (int r = 0; r < 6; r++) begin
      int len;
      rs = $urandom_range(0, 1);
      len = $urandom_range(1, 8);
      stimWords.delete();
      for (int i = 0; i < len; i++) stimWords.push_back($urandom);
      doLoad(rs, len, 1'b0);
      doDump(rs, $urandom_range(1, len + 2), $urandom_range(0, 3));
    end

    stimWords.delete();
    for (int i = 0; i < 4096; i++) stimWords.push_back($urandom);
    doLoad(1'b1, 5000, 1'b1);
    checkOutput("bigLastAddr", writeLog[writeLog.size() - 1].addr, 32'h3FFC);
    doDump(1'b1, 6, 1);

    writeLog.delete();
    d0 = doneCount;
    applyStimulus(2'b00, 1'b0, 13'd4);
    wr_valid = 1'b1;
    wr_data  = 32'hA1A1A1A1;
    tick();
    wr_data  = 32'hA2A2A2A2;
    tick();
    CPU_RST  = 1'b0;
    wr_data  = 32'hA3A3A3A3;
    tick();
    checkOutput("midRstDataWe", 32'(data_we2), 32'd0);
    checkOutput("midRstInstWe", 32'(inst_we2), 32'd0);
    checkOutput("midRstIdle", 32'(cmd_ready), 32'd1);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstSum", checksum, 32'd0);
    CPU_RST = 1'b1;
    repeat (3) tick();
    wr_valid = 1'b0;
    tick();
    checkOutput("midRstWrites", writeLog.size(), 2);
    checkOutput("midRstNoDone", doneCount - d0, 0);
    if (writeLog.size() >= 2) begin
      checkOutput("midRstW0", writeLog[0].data, 32'hA1A1A1A1);
      checkOutput("midRstW1Addr", writeLog[1].addr, 32'h4);
    end
    modelMem[0][0] = 32'hA1A1A1A1;
    modelMem[0][1] = 32'hA2A2A2A2;
    doDump(1'b0, 4, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
